data_sram_bridge: RTL

//  Sits between the CPU memory stage and data memory. Converts the single-cycle
//    M-stage port (ALUOutM, writeData2M, mem_wenM plus a read/write enable) into a
//    req/addr_ok/data_ok SRAM-like bus.

---
 rtl/data_sram_bridge.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/data_sram_bridge.sv
// data_sram_bridge: converts the single-cycle M-stage memory port into a
// req/addr_ok/data_ok SRAM-like bus, stalling the pipeline until done.
// Ports: clk (rising edge), rst (async, active-low);
//   cpu_en/cpu_wen/cpu_addr/cpu_wdata in, cpu_rdata/cpu_stall out;
//   bus_req/bus_wr/bus_size/bus_addr/bus_wstrb/bus_wdata out,
//   bus_addr_ok/bus_data_ok/bus_rdata in; bus_err sticky timeout flag.
module data_sram_bridge #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cpu_en,
   input  logic [3:0]        cpu_wen,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_stall,
   output logic              bus_req,
   output logic              bus_wr,
   output logic [1:0]        bus_size,
   output logic [ADDR_W-1:0] bus_addr,
   output logic [3:0]        bus_wstrb,
   output logic [DATA_W-1:0] bus_wdata,
   input  logic              bus_addr_ok,
   input  logic              bus_data_ok,
   input  logic [DATA_W-1:0] bus_rdata,
   output logic              bus_err
);

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      WAIT,
      DONE
   } state_t;

   localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

   state_t        stateQ;
   state_t        stateD;
   logic [CW-1:0] toCnt;
   logic [CW-1:0] toCntInc;
   logic          busy;
   logic          complete;
   logic          timeoutHit;
   logic          timeoutFire;
   logic [1:0]    sizeDec;
   logic [1:0]    offDec;

   assign busy     = (stateQ == REQ) || (stateQ == WAIT);
   assign toCntInc = toCnt + 1'b1;

   // A transaction that finishes on the same cycle the budget runs out
   // keeps its real data rather than being reported as a timeout.
   assign complete = ((stateQ == REQ) && bus_addr_ok && bus_data_ok)
                  || ((stateQ == WAIT) && bus_data_ok);

   assign timeoutHit  = (TIMEOUT > 0) && busy
                     && (toCntInc == CW'(TIMEOUT));
   assign timeoutFire = timeoutHit && !complete;

   // Reset forces the stall low even though IDLE would otherwise stall.
   assign cpu_stall = rst && cpu_en && (stateQ != DONE);

   always_comb begin
      sizeDec = 2'd2;
      offDec  = 2'd0;
      case (cpu_wen)
         4'b0011: sizeDec = 2'd1;
         4'b1100: begin
            sizeDec = 2'd1;
            offDec  = 2'd2;
         end
         4'b0001: sizeDec = 2'd0;
         4'b0010: begin
            sizeDec = 2'd0;
            offDec  = 2'd1;
         end
         4'b0100: begin
            sizeDec = 2'd0;
            offDec  = 2'd2;
         end
         4'b1000: begin
            sizeDec = 2'd0;
            offDec  = 2'd3;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stateQ <= IDLE;
      end else begin
         stateQ <= stateD;
      end
   end

   always_comb begin
      stateD = stateQ;
      case (stateQ)
         IDLE: begin
            if (cpu_en) stateD = REQ;
         end
         REQ: begin
            if (complete)         stateD = DONE;
            else if (timeoutHit)  stateD = DONE;
            else if (bus_addr_ok) stateD = WAIT;
         end
         WAIT: begin
            if (complete || timeoutHit) stateD = DONE;
         end
         DONE:    stateD = IDLE;
         default: stateD = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bus_req   <= 1'b0;
         bus_wr    <= 1'b0;
         bus_size  <= 2'd0;
         bus_addr  <= '0;
         bus_wstrb <= 4'd0;
         bus_wdata <= '0;
         cpu_rdata <= '0;
         bus_err   <= 1'b0;
         toCnt     <= '0;
      end else begin
         if ((stateQ == IDLE) && cpu_en) begin
            bus_req   <= 1'b1;
            bus_wr    <= |cpu_wen;
            bus_size  <= sizeDec;
            bus_addr  <= {cpu_addr[ADDR_W-1:2], offDec};
            bus_wstrb <= cpu_wen;
            bus_wdata <= cpu_wdata;
         end
         if ((stateQ == REQ) && (bus_addr_ok || timeoutFire)) begin
            bus_req <= 1'b0;
         end
         if (complete && !bus_wr) begin
            cpu_rdata <= bus_rdata;
         end
         if (timeoutFire) begin
            cpu_rdata <= '0;
            bus_err   <= 1'b1;
         end
         if ((TIMEOUT > 0) && busy) begin
            toCnt <= toCntInc;
         end else begin
            toCnt <= '0;
         end
      end
   end

endmodule
